track_sequencer: RTL and testbench
==================================

Name: track_sequencer

Overview:
- Playback controller for one 32x4 note-track RAM in the Guitar Hero design.
- Steps through the track addresses at a fixed beat rate and absorbs the RAM's one-cycle read latency.
- Presents each 4-bit note row to the note/display logic.
- Shares the RAM single port with an edit/loader requester so tracks can be written between beats.

Parameters:
- BEAT_DIV, 12500000: clock cycles per beat (4 Hz at 50 MHz); minimum 4.
- LOOP, 0: 1 = wrap from step 31 to step 0; 0 = stop after step 31.

Ports:
- clock  in  1  system clock; all logic is clocked on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  level; starts playback from step 0 when in IDLE or DONE.
- pause  in  1  level; freezes the beat counter while high.
- edit_req  in  1  write request; held high until edit_ack.
- edit_addr  in  5  write address.
- edit_data  in  4  write data.
- edit_ack  out  1  one-cycle pulse in the cycle the write is issued.
- ram_address  out  5  to RAM address.
- ram_data  out  4  to RAM data.
- ram_wren  out  1  to RAM wren.
- ram_q  in  4  from RAM q; valid in the cycle after the address is sampled.
- note_row  out  4  registered current note row.
- note_valid  out  1  one-cycle pulse when note_row updates.
- step_idx  out  5  index of the row currently in note_row.
- playing  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (resetn low at a clock edge, any state, including mid-fetch or mid-write):
  - state goes to IDLE; beat counter and tick_pending are cleared.
  - All outputs are 0: ram_address, ram_data, ram_wren, note_row, note_valid, step_idx, edit_ack, playing, done.
- States: IDLE, WAIT_TICK, FETCH, LATCH, WRITE, DONE.
- IDLE:
  - start=1: step_idx<=0, go to FETCH. Fetch of row 0 is immediate, with no beat wait.
  - Otherwise, edit_req=1: go to WRITE.
- FETCH:
  - ram_address=step_idx, ram_wren=0.
  - Next state is LATCH.
- LATCH:
  - note_row<=ram_q; note_valid pulses in the following cycle.
  - Next state is WAIT_TICK.
  - Start-to-note_valid latency is 3 cycles (FETCH, LATCH, pulse).
- Beat counter:
  - Runs 0..BEAT_DIV-1 while playing=1 and pause=0; holds its value while pause=1.
  - It is cleared when entering FETCH from IDLE or DONE.
  - tick asserts for the one cycle the counter equals BEAT_DIV-1 (and pause=0).
  - A tick during FETCH, LATCH or WRITE sets tick_pending. A pending tick is consumed on return to WAIT_TICK; at most one tick is remembered.
- WAIT_TICK:
  - On tick or tick_pending:
    - step_idx<31: step_idx+1, go to FETCH.
    - step_idx=31 and LOOP=1: step_idx<=0, go to FETCH.
    - step_idx=31 and LOOP=0: go to DONE; note_row<=0.
  - Else if edit_req=1: go to WRITE.
  - Priority: a tick beats edit_req in the same cycle.
- WRITE:
  - For exactly one cycle: ram_address=edit_addr, ram_data=edit_data, ram_wren=1, edit_ack=1.
  - Returns to the state it came from (IDLE or WAIT_TICK).
  - edit_req must drop after ack. If it is still high it is treated as a new request, serviced no sooner than one cycle later.
- DONE:
  - done=1, playing=0, note_row=0.
  - start=1 behaves as in IDLE; edit_req is serviced as in IDLE.
- ram_wren is 1 only in WRITE; ram_data=0 outside WRITE.
- ram_address holds its last value in IDLE, WAIT_TICK and DONE.
- start while playing is ignored.
- pause while in FETCH or LATCH does not stall the in-flight fetch.

Test Plan:
1. Basic playback (BEAT_DIV=4, LOOP=0; RAM preloaded with row0=1010, row1=0101, row31=1111):
   - Pulse start → note_row=1010 with note_valid 3 cycles later.
   - Then 0101 exactly 4 cycles after that, step_idx=1.
2. End of track: run to step 31 → note_row=1111, then on the next tick done=1, playing=0, note_row=0. A further start restarts at row 0.
3. Wrap: LOOP=1 → after step 31 (1111) the next valid gives step_idx=0, note_row=1010, done stays 0.
4. Edit arbitration:
   - edit_req (addr 3, data 0110) in WAIT_TICK → edit_ack and ram_wren high for one cycle with ram_address=3.
   - The same-cycle tick case must fetch first and ack on a later cycle.
   - Playback of step 3 then shows 0110.
5. Pause: assert pause for 10 cycles mid-beat → the next note_valid is delayed by exactly 10 cycles and step order is unchanged.
6. Reset mid-operation: drop resetn during WRITE and during LATCH → at the next edge all outputs are 0, state is IDLE, and the RAM content at the target address is unchanged by the aborted cycle's successors.

Source files
------------

// File: rtl/track_sequencer_if.sv
// rtl/track_sequencer_if.sv - control, edit and RAM bus bundle for track_sequencer
// Ports grouped here:
//   start, pause                     playback control levels
//   edit_req/addr/data, edit_ack     edit/loader write request and acknowledge
//   ram_address/data/wren, ram_q     single-port note-track RAM
//   note_row, note_valid, step_idx   current note row to the note/display logic
//   playing, done                    playback status
// master: the sequencer side; slave: the surrounding system side.
interface track_sequencer_if;
  logic       start;
  logic       pause;
  logic       edit_req;
  logic [4:0] edit_addr;
  logic [3:0] edit_data;
  logic       edit_ack;
  logic [4:0] ram_address;
  logic [3:0] ram_data;
  logic       ram_wren;
  logic [3:0] ram_q;
  logic [3:0] note_row;
  logic       note_valid;
  logic [4:0] step_idx;
  logic       playing;
  logic       done;

  modport master (
    input  start, pause, edit_req, edit_addr, edit_data, ram_q,
    output edit_ack, ram_address, ram_data, ram_wren,
           note_row, note_valid, step_idx, playing, done
  );

  modport slave (
    output start, pause, edit_req, edit_addr, edit_data, ram_q,
    input  edit_ack, ram_address, ram_data, ram_wren,
           note_row, note_valid, step_idx, playing, done
  );
endinterface

// File: rtl/track_sequencer.sv
// rtl/track_sequencer.sv - beat-paced playback of a 32x4 note track with edit port sharing
// Ports:
//   clock   rising-edge system clock
//   resetn  synchronous active-low reset
//   bus     track_sequencer_if.master (control, edit request, RAM port, note outputs)
// Parameters:
//   BEAT_DIV  clock cycles per beat (>= 4)
//   LOOP      1 = wrap from step 31 to step 0, 0 = stop after step 31
module track_sequencer #(
  parameter int BEAT_DIV = 12500000,
  parameter bit LOOP     = 1'b0
) (
  input  logic                clock,
  input  logic                resetn,
  track_sequencer_if.master   bus
);

  localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, FETCH, LATCH, WRITE, DONE
  } state_t;

  state_t        state, state_nx;
  state_t        ret_state, ret_nx;
  logic [CW-1:0] beat_cnt;
  logic          tick_pending;
  logic          tick;
  logic          restart;
  logic          consume;
  logic [4:0]    step_idx, step_nx;
  logic [3:0]    note_row, row_nx;
  logic          note_valid, valid_nx;
  logic [4:0]    addr_hold;
  logic [4:0]    ram_address;
  logic          playing;

  assign playing = (state != IDLE) && (state != DONE);
  assign tick    = playing && !bus.pause && (beat_cnt == BEAT_LAST);

  // RAM address is combinational so the RAM samples it at the end of FETCH;
  // outside FETCH/WRITE it replays the last issued address.
  always_comb begin
    ram_address = addr_hold;
    if (state == FETCH)      ram_address = step_idx;
    else if (state == WRITE) ram_address = bus.edit_addr;
  end

  assign bus.ram_address = ram_address;
  assign bus.ram_data    = (state == WRITE) ? bus.edit_data : 4'd0;
  assign bus.ram_wren    = (state == WRITE);
  assign bus.edit_ack    = (state == WRITE);
  assign bus.note_row    = note_row;
  assign bus.note_valid  = note_valid;
  assign bus.step_idx    = step_idx;
  assign bus.playing     = playing;
  assign bus.done        = (state == DONE);

  always_comb begin
    state_nx = state;
    ret_nx   = ret_state;
    step_nx  = step_idx;
    row_nx   = note_row;
    valid_nx = 1'b0;
    restart  = 1'b0;
    consume  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          step_nx  = 5'd0;
          state_nx = FETCH;
          restart  = 1'b1;
        end else if (bus.edit_req) begin
          state_nx = WRITE;
          ret_nx   = state;
        end
      end
      FETCH: state_nx = LATCH;
      LATCH: begin
        row_nx   = bus.ram_q;
        valid_nx = 1'b1;
        state_nx = WAIT_TICK;
      end
      WAIT_TICK: begin
        // A beat always wins over an edit request in the same cycle.
        if (tick || tick_pending) begin
          consume = 1'b1;
          if (step_idx != 5'd31) begin
            step_nx  = step_idx + 5'd1;
            state_nx = FETCH;
          end else if (LOOP) begin
            step_nx  = 5'd0;
            state_nx = FETCH;
          end else begin
            row_nx   = 4'd0;
            state_nx = DONE;
          end
        end else if (bus.edit_req) begin
          state_nx = WRITE;
          ret_nx   = WAIT_TICK;
        end
      end
      WRITE:   state_nx = ret_state;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      ret_state    <= IDLE;
      step_idx     <= 5'd0;
      note_row     <= 4'd0;
      note_valid   <= 1'b0;
      addr_hold    <= 5'd0;
      beat_cnt     <= '0;
      tick_pending <= 1'b0;
    end else begin
      state      <= state_nx;
      ret_state  <= ret_nx;
      step_idx   <= step_nx;
      note_row   <= row_nx;
      note_valid <= valid_nx;
      addr_hold  <= ram_address;

      if (restart)
        beat_cnt <= '0;
      else if (playing && !bus.pause)
        beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;

      // Only one missed beat is remembered while the port is busy.
      if (restart || consume)
        tick_pending <= 1'b0;
      else if (tick && (state == FETCH || state == LATCH || state == WRITE))
        tick_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_track_sequencer.sv
// tb/tb_track_sequencer.sv - directed self-checking bench for track_sequencer
module tb_track_sequencer;

  logic clock = 1'b0;
  logic resetn;
  logic preload;
  logic sel;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [3:0] mem0 [32];
  logic [3:0] mem1 [32];

  track_sequencer_if a ();
  track_sequencer_if b ();

  track_sequencer #(.BEAT_DIV(4), .LOOP(1'b0)) dut0 (.clock(clock), .resetn(resetn), .bus(a.master));
  track_sequencer #(.BEAT_DIV(4), .LOOP(1'b1)) dut1 (.clock(clock), .resetn(resetn), .bus(b.master));

  always #5 clock = ~clock;

  function automatic logic [3:0] init_row(input int i);
    if (i == 0)  return 4'b1010;
    if (i == 1)  return 4'b0101;
    if (i == 31) return 4'b1111;
    return 4'(i);
  endfunction

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= init_row(i);
        mem1[i] <= init_row(i);
      end
      a.ram_q <= 4'd0;
      b.ram_q <= 4'd0;
    end else begin
      if (a.ram_wren) mem0[a.ram_address] <= a.ram_data;
      if (b.ram_wren) mem1[b.ram_address] <= b.ram_data;
      a.ram_q <= mem0[a.ram_address];
      b.ram_q <= mem1[b.ram_address];
    end
  end

  wire        mv   = sel ? b.note_valid : a.note_valid;
  wire [3:0]  mrow = sel ? b.note_row   : a.note_row;
  wire [4:0]  midx = sel ? b.step_idx   : a.step_idx;
  wire        mdone = sel ? b.done      : a.done;
  wire [22:0] a_outs = {a.ram_address, a.ram_data, a.ram_wren, a.note_row, a.note_valid,
                        a.step_idx, a.edit_ack, a.playing, a.done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!mv && n < 20);
    if (!mv) begin
      check("wait_valid_timeout", 32'd0, 32'd1);
      n = -1;
    end
  endtask

  int  n;
  logic seen;

  initial begin
    resetn = 1'b0; preload = 1'b1; sel = 1'b0;
    a.start = 0; a.pause = 0; a.edit_req = 0; a.edit_addr = 0; a.edit_data = 0;
    b.start = 0; b.pause = 0; b.edit_req = 0; b.edit_addr = 0; b.edit_data = 0;
    step();
    preload = 1'b0;
    step();
    check("reset_outputs", 32'(a_outs), 32'd0);
    resetn = 1'b1;

    // Basic playback
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    check("playing_in_fetch", 32'(a.playing), 32'd1);
    step();
    check("no_valid_in_latch", 32'(a.note_valid), 32'd0);
    step();
    check("row0_valid", 32'(a.note_valid), 32'd1);
    check("row0_data", 32'(a.note_row), 32'hA);
    check("row0_idx", 32'(a.step_idx), 32'd0);
    step();
    check("valid_one_cycle", 32'(a.note_valid), 32'd0);
    step(); step(); step();
    check("row1_valid", 32'(a.note_valid), 32'd1);
    check("row1_data", 32'(a.note_row), 32'h5);
    check("row1_idx", 32'(a.step_idx), 32'd1);

    // End of track
    for (int k = 2; k < 32; k++) begin
      wait_valid(n);
      check("step_order", 32'(a.step_idx), 32'(k));
    end
    check("row31_data", 32'(a.note_row), 32'hF);
    check("row31_spacing", 32'(n), 32'd4);
    step();
    check("not_done_yet", 32'(a.done), 32'd0);
    step();
    check("done_high", 32'(a.done), 32'd1);
    check("done_not_playing", 32'(a.playing), 32'd0);
    check("done_row_zero", 32'(a.note_row), 32'd0);
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    step(); step();
    check("restart_valid", 32'(a.note_valid), 32'd1);
    check("restart_row", 32'(a.note_row), 32'hA);
    check("restart_idx", 32'(a.step_idx), 32'd0);
    check("restart_done", 32'(a.done), 32'd0);

    // Edit arbitration
    a.edit_req = 1'b1; a.edit_addr = 5'd3; a.edit_data = 4'b0110;
    step();
    check("edit_ack", 32'(a.edit_ack), 32'd1);
    check("edit_wren", 32'(a.ram_wren), 32'd1);
    check("edit_addr", 32'(a.ram_address), 32'd3);
    check("edit_data", 32'(a.ram_data), 32'h6);
    a.edit_req = 1'b0;
    step();
    check("edit_ack_drop", 32'({a.edit_ack, a.ram_wren}), 32'd0);
    check("ram_row3_written", 32'(mem0[3]), 32'h6);
    wait_valid(n);
    wait_valid(n);
    check("after_edit_idx", 32'(a.step_idx), 32'd2);
    step();
    a.edit_req = 1'b1; a.edit_addr = 5'd5; a.edit_data = 4'b1001;
    step();
    check("tick_wins_ack", 32'(a.edit_ack), 32'd0);
    check("tick_wins_addr", 32'(a.ram_address), 32'd3);
    check("tick_wins_idx", 32'(a.step_idx), 32'd3);
    step();
    check("latch_no_ack", 32'(a.edit_ack), 32'd0);
    step();
    check("row3_valid", 32'(a.note_valid), 32'd1);
    check("row3_edited", 32'(a.note_row), 32'h6);
    step();
    check("late_ack", 32'(a.edit_ack), 32'd1);
    check("late_ack_addr", 32'(a.ram_address), 32'd5);
    a.edit_req = 1'b0;
    step();
    check("ram_row5_written", 32'(mem0[5]), 32'h9);
    wait_valid(n);
    wait_valid(n);
    check("row5_edited", 32'(a.note_row), 32'h9);
    wait_valid(n);
    check("row6_spacing", 32'(n), 32'd4);
    check("row6_idx", 32'(a.step_idx), 32'd6);

    // Pause
    a.pause = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a.note_valid) seen = 1'b1;
    end
    a.pause = 1'b0;
    check("no_valid_while_paused", 32'(seen), 32'd0);
    wait_valid(n);
    check("pause_gap", 32'(10 + n), 32'd14);
    check("pause_idx", 32'(a.step_idx), 32'd7);
    check("pause_row", 32'(a.note_row), 32'h7);

    // Wrap
    sel = 1'b1;
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    step(); step();
    check("loop_row0", 32'({mv, mrow}), 32'h1A);
    for (int k = 1; k < 32; k++) wait_valid(n);
    check("loop_idx31", 32'(midx), 32'd31);
    check("loop_row31", 32'(mrow), 32'hF);
    wait_valid(n);
    check("wrap_idx", 32'(midx), 32'd0);
    check("wrap_row", 32'(mrow), 32'hA);
    check("wrap_not_done", 32'(mdone), 32'd0);
    check("wrap_spacing", 32'(n), 32'd4);
    sel = 1'b0;

    // Reset during WRITE
    a.edit_req = 1'b1; a.edit_addr = 5'd7; a.edit_data = 4'b1100;
    n = 0;
    while (!a.edit_ack && n < 20) begin
      step();
      n++;
    end
    check("write_reached", 32'(a.edit_ack), 32'd1);
    resetn = 1'b0;
    step();
    check("reset_in_write", 32'(a_outs), 32'd0);
    a.edit_req = 1'b0;
    resetn = 1'b1;
    step();
    check("no_write_after_reset", 32'(a.ram_wren), 32'd0);
    check("ram_row7_after_reset", 32'(mem0[7]), 32'hC);
    check("row8_untouched", 32'(mem0[8]), 32'h8);

    // Reset during LATCH
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    step();
    resetn = 1'b0;
    step();
    check("reset_in_latch", 32'(a_outs), 32'd0);
    resetn = 1'b1;
    step(); step();
    check("idle_after_reset", 32'({a.note_valid, a.playing}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
